// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//   Converts a debounced, clk-domain button level into discrete events:
//   PRESS on the rising edge, LONG after the button has been held for
//   LONG_CYCLES, then REPEAT every REPEAT_CYCLES for as long as it stays held,
//   and RELEASE on the falling edge. Events are presented through a
//   single-entry valid/ready register. A new event that arrives while an
//   older one is still waiting is dropped, and a sticky overflow flag is set.
//
// Parameters
//   LONG_CYCLES    held cycles from PRESS to LONG          (>= 2)
//   REPEAT_CYCLES  held cycles between successive REPEATs   (>= 2)
//   CNT_W          hold-counter width, holds max(LONG,REPEAT)-1
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   btn_in       in   debounced button level
//   event_valid  out  an event is pending
//   event_code   out  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   event_ready  in   consumer accepts the pending event
//   pressed      out  high while the FSM is outside IDLE
//   overflow     out  sticky, set when an event is dropped
// -----------------------------------------------------------------------------
module button_event #(
    parameter int unsigned LONG_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       event_valid,
    output logic [1:0] event_code,
    input  logic       event_ready,
    output logic       pressed,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    // Terminal counts. The counter is cleared on entry to each hold state, so
    // it reaches *_TC exactly *_CYCLES edges after the event that cleared it.
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             prev;
    logic             rise, fall;
    logic             new_evt;
    logic [1:0]       new_code;
    logic             transfer;

    assign rise     = btn_in & ~prev;
    assign fall     = ~btn_in & prev;
    assign transfer = event_valid & event_ready;

    // ------------------------------------------------------------------
    // FSM state, hold counter and edge-detect register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            prev  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            prev  <= btn_in;
        end
    end

    // ------------------------------------------------------------------
    // Next state, counter and event generation.
    // A fall always wins over a terminal count in the same cycle, so a
    // release exactly at the LONG/REPEAT point reports RELEASE only.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        new_evt   = 1'b0;
        new_code  = EV_PRESS;

        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    new_evt   = 1'b1;
                    new_code  = EV_PRESS;
                    state_nxt = ST_HELD;
                end
            end

            ST_HELD: begin
                if (fall) begin
                    new_evt   = 1'b1;
                    new_code  = EV_RELEASE;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt == LONG_TC) begin
                    new_evt   = 1'b1;
                    new_code  = EV_LONG;
                    cnt_nxt   = '0;
                    state_nxt = ST_REPEAT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_REPEAT: begin
                if (fall) begin
                    new_evt   = 1'b1;
                    new_code  = EV_RELEASE;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt == REPEAT_TC) begin
                    new_evt  = 1'b1;
                    new_code = EV_REPEAT;
                    cnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-entry event register.
    // The slot is free if it is empty or is being drained on this edge;
    // otherwise the new event is lost and overflow latches until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            event_valid <= 1'b0;
            event_code  <= EV_PRESS;
            overflow    <= 1'b0;
        end else if (new_evt) begin
            if (!event_valid || transfer) begin
                event_valid <= 1'b1;
                event_code  <= new_code;
            end else begin
                overflow <= 1'b1;
            end
        end else if (transfer) begin
            event_valid <= 1'b0;
        end
    end

    // pressed follows the state being entered, so it rises on the PRESS
    // edge and falls on the RELEASE edge.
    always_ff @(posedge clk) begin
        if (rst) pressed <= 1'b0;
        else     pressed <= (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//   Self-checking bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
//   A behavioural model tracks how many edges the button has been held since
//   PRESS and derives LONG/REPEAT from that duration arithmetically, then
//   applies the one-slot handshake rules. Directed scenarios run first,
//   followed by randomized button/ready/reset activity.
// -----------------------------------------------------------------------------
module tb_button_event;

    localparam int LONG   = 8;
    localparam int REPEAT = 4;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       event_valid;
    logic [1:0] event_code;
    logic       event_ready;
    logic       pressed;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // model state
    bit       m_prev;
    bit       m_held;
    int       m_t;        // edges since the PRESS edge
    bit       m_valid;
    bit [1:0] m_code;
    bit       m_ovf;

    button_event #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REPEAT),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .event_valid(event_valid),
        .event_code (event_code),
        .event_ready(event_ready),
        .pressed    (pressed),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        bit       ev;
        bit [1:0] code;
        bit       rise, fall, xfer;
        ev   = 1'b0;
        code = 2'b00;
        if (rst) begin
            m_prev  = 1'b0;
            m_held  = 1'b0;
            m_t     = 0;
            m_valid = 1'b0;
            m_code  = 2'b00;
            m_ovf   = 1'b0;
            return;
        end
        rise = btn_in & ~m_prev;
        fall = ~btn_in & m_prev;
        if (!m_held) begin
            if (rise) begin
                ev = 1'b1; code = 2'b00; m_held = 1'b1; m_t = 0;
            end
        end else if (fall) begin
            ev = 1'b1; code = 2'b01; m_held = 1'b0;
        end else begin
            m_t++;
            if (m_t == LONG) begin
                ev = 1'b1; code = 2'b10;
            end else if (m_t > LONG && ((m_t - LONG) % REPEAT) == 0) begin
                ev = 1'b1; code = 2'b11;
            end
        end
        xfer = m_valid & event_ready;
        if (ev) begin
            if (!m_valid || xfer) begin
                m_valid = 1'b1; m_code = code;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        m_prev = btn_in;
    endtask

    // One clock: drive at negedge, update model, compare #1 after posedge.
    task automatic step(input logic b, input logic r, input logic rs);
        @(negedge clk);
        btn_in      = b;
        event_ready = r;
        rst         = rs;
        model_edge();
        @(posedge clk);
        #1;
        chk("valid",    event_valid, m_valid);
        chk("code",     event_code,  m_code);
        chk("pressed",  pressed,     m_held);
        chk("overflow", overflow,    m_ovf);
    endtask

    task automatic run(input logic b, input logic r, input int n);
        for (int i = 0; i < n; i++) step(b, r, 1'b0);
    endtask

    initial begin
        logic b;
        btn_in      = 1'b0;
        event_ready = 1'b1;
        rst         = 1'b1;

        // reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        chk("rst_valid",   event_valid, 0);
        chk("rst_code",    event_code,  0);
        chk("rst_pressed", pressed,     0);
        chk("rst_ovf",     overflow,    0);

        // short press
        run(1'b0, 1'b1, 5);
        run(1'b1, 1'b1, 4);
        run(1'b0, 1'b1, 4);

        // long hold: PRESS, LONG, two REPEATs, RELEASE
        run(1'b1, 1'b1, 20);
        chk("long_pressed", pressed, 1);
        run(1'b0, 1'b1, 4);

        // fall exactly on the LONG terminal count
        run(1'b1, 1'b1, LONG);
        step(1'b0, 1'b1, 1'b0);
        chk("tc_fall_code", event_code, 2'b01);
        run(1'b0, 1'b1, 3);

        // back-pressure: PRESS held pending, RELEASE dropped
        run(1'b1, 1'b0, 2);
        run(1'b0, 1'b0, 3);
        chk("bp_code", event_code, 2'b00);
        chk("bp_ovf",  overflow,   1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("bp_drain", event_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);

        // reset mid-hold with button still held, then PRESS again
        run(1'b1, 1'b1, 10);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_hold_pressed", pressed, 0);
        chk("rst_hold_ovf",     overflow, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_repress_code",  event_code,  2'b00);
        chk("rst_repress_valid", event_valid, 1);
        run(1'b1, 1'b1, 12);
        run(1'b0, 1'b1, 3);

        // randomized activity
        b = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) b = ~b;
            step(b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
